// File: rtl/task_5.sv
// Baccarat dealer/evaluator: free-running 1..13 card counter, step-driven deal FSM,
// card display on HEX0-HEX5, scores and winner on LEDR.
module task_5 (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);
    localparam int unsigned CW = 4;
    localparam int unsigned SW = 5;

    typedef enum logic [3:0] {
        PC1, DC1, PC2, DC2, EVAL2, PC3, EVAL3, DC3, DONE
    } state_t;

    logic          clk;
    logic          rst;
    logic          step;
    logic          prev;
    logic [CW-1:0] cnt;
    state_t        state;
    logic [CW-1:0] pcard1, pcard2, pcard3;
    logic [CW-1:0] dcard1, dcard2, dcard3;
    logic [CW-1:0] pscore, dscore;
    logic [1:0]    win;
    logic          unused;

    assign clk    = CLOCK_50;
    assign rst    = KEY[3];
    assign step   = KEY[0] & ~prev;
    assign unused = ^KEY[2:1];

    // Baccarat value of a card code: tens and faces (and empty) count zero
    function automatic logic [CW-1:0] card_val(input logic [CW-1:0] c);
        return (c >= CW'(1) && c <= CW'(9)) ? c : CW'(0);
    endfunction

    function automatic logic [CW-1:0] hand_score(input logic [CW-1:0] a,
                                                 input logic [CW-1:0] b,
                                                 input logic [CW-1:0] c);
        logic [SW-1:0] sum;
        sum = SW'(card_val(a)) + SW'(card_val(b)) + SW'(card_val(c));
        if (sum >= SW'(20))      sum = sum - SW'(20);
        else if (sum >= SW'(10)) sum = sum - SW'(10);
        return CW'(sum);
    endfunction

    // Dealer third-card rule given dealer score and player's third card value
    function automatic logic dealer_draws(input logic [CW-1:0] d, input logic [CW-1:0] p3);
        logic draw;
        draw = 1'b0;
        case (d)
            CW'(0), CW'(1), CW'(2): draw = 1'b1;
            CW'(3): draw = (p3 != CW'(8));
            CW'(4): draw = (p3 >= CW'(2)) && (p3 <= CW'(7));
            CW'(5): draw = (p3 >= CW'(4)) && (p3 <= CW'(7));
            CW'(6): draw = (p3 >= CW'(6)) && (p3 <= CW'(7));
            default: draw = 1'b0;
        endcase
        return draw;
    endfunction

    function automatic logic [6:0] seg(input logic [CW-1:0] c);
        logic [6:0] s;
        case (c)
            CW'(1):  s = 7'b0001000;
            CW'(2):  s = 7'b0100100;
            CW'(3):  s = 7'b0110000;
            CW'(4):  s = 7'b0011001;
            CW'(5):  s = 7'b0010010;
            CW'(6):  s = 7'b0000010;
            CW'(7):  s = 7'b1111000;
            CW'(8):  s = 7'b0000000;
            CW'(9):  s = 7'b0010000;
            CW'(10): s = 7'b1000000;
            CW'(11): s = 7'b1100001;
            CW'(12): s = 7'b0011000;
            CW'(13): s = 7'b0001001;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        pscore = hand_score(pcard1, pcard2, pcard3);
        dscore = hand_score(dcard1, dcard2, dcard3);
    end

    // Counter, step edge history, win lights and deal FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PC1;
            cnt    <= CW'(1);
            prev   <= 1'b1;
            win    <= 2'b00;
            pcard1 <= '0;
            pcard2 <= '0;
            pcard3 <= '0;
            dcard1 <= '0;
            dcard2 <= '0;
            dcard3 <= '0;
        end else begin
            prev <= KEY[0];
            cnt  <= (cnt == CW'(13)) ? CW'(1) : cnt + CW'(1);
            win  <= (state == DONE) ? {dscore >= pscore, pscore >= dscore} : 2'b00;
            case (state)
                PC1: if (step) begin pcard1 <= cnt; state <= DC1;   end
                DC1: if (step) begin dcard1 <= cnt; state <= PC2;   end
                PC2: if (step) begin pcard2 <= cnt; state <= DC2;   end
                DC2: if (step) begin dcard2 <= cnt; state <= EVAL2; end
                EVAL2: begin
                    if (pscore >= CW'(8) || dscore >= CW'(8)) state <= DONE;
                    else if (pscore <= CW'(5))                state <= PC3;
                    else if (dscore <= CW'(5))                state <= DC3;
                    else                                      state <= DONE;
                end
                PC3: if (step) begin pcard3 <= cnt; state <= EVAL3; end
                EVAL3: state <= dealer_draws(dscore, card_val(pcard3)) ? DC3 : DONE;
                DC3: if (step) begin dcard3 <= cnt; state <= DONE;  end
                default: state <= DONE;
            endcase
        end
    end

    assign LEDR = {win, dscore, pscore};
    assign HEX0 = seg(pcard1);
    assign HEX1 = seg(pcard2);
    assign HEX2 = seg(pcard3);
    assign HEX3 = seg(dcard1);
    assign HEX4 = seg(dcard2);
    assign HEX5 = seg(dcard3);
endmodule

// File: tb/tb_task_5.sv
// Directed bench for task_5: deals chosen cards by timing steps against a model
// of the free-running counter and checks HEX/LEDR against hand-computed values.
module tb_task_5;
    logic       clk = 1'b0;
    logic [3:0] key;
    logic [9:0] ledr;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    int         errors = 0;
    int         checks = 0;
    int         cnt    = 1;

    localparam logic [6:0] BLANK = 7'b1111111;

    always #5 clk = ~clk;

    task_5 dut (
        .CLOCK_50(clk),
        .KEY     (key),
        .LEDR    (ledr),
        .HEX0    (hex0),
        .HEX1    (hex1),
        .HEX2    (hex2),
        .HEX3    (hex3),
        .HEX4    (hex4),
        .HEX5    (hex5)
    );

    function automatic logic [6:0] seg(input int c);
        case (c)
            1:  return 7'b0001000;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b1000000;
            11: return 7'b1100001;
            12: return 7'b0011000;
            13: return 7'b0001001;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; cnt tracks the value the DUT counter will load at the next edge
    task automatic tick();
        @(posedge clk);
        cnt = (cnt == 13) ? 1 : cnt + 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        key[3] = 1'b1;
        @(posedge clk);
        cnt = 1;
        @(negedge clk);
        key[3] = 1'b0;
    endtask

    // Idle one clock with KEY[0] low, wait for card v, then raise KEY[0] for that edge
    task automatic deal(input int v);
        tick();
        while (cnt != v) tick();
        key[0] = 1'b1;
        tick();
        key[0] = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_hex0"}, 16'(hex0), 16'(BLANK));
        check({tag, "_hex1"}, 16'(hex1), 16'(BLANK));
        check({tag, "_hex2"}, 16'(hex2), 16'(BLANK));
        check({tag, "_hex3"}, 16'(hex3), 16'(BLANK));
        check({tag, "_hex4"}, 16'(hex4), 16'(BLANK));
        check({tag, "_hex5"}, 16'(hex5), 16'(BLANK));
        check({tag, "_ledr"}, 16'(ledr), 16'h0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        key = 4'b0000;
        @(negedge clk);
        do_reset();
        check_cleared("reset");

        // Player first card and natural 9 vs 1
        deal(1);
        check("p1_hex0", 16'(hex0), 16'(seg(1)));
        check("p1_pscore", 16'(ledr[3:0]), 16'd1);
        check("p1_win", 16'(ledr[9:8]), 16'd0);
        check("p1_hex1", 16'(hex1), 16'(BLANK));
        deal(1);
        deal(8);
        deal(11);
        check("nat_win_k0", 16'(ledr[9:8]), 16'd0);
        tick();
        check("nat_win_k1", 16'(ledr[9:8]), 16'd0);
        tick();
        check("nat_win_k2", 16'(ledr[9:8]), 16'b01);
        check("nat_hex1", 16'(hex1), 16'(seg(8)));
        check("nat_hex4", 16'(hex4), 16'(seg(11)));
        check("nat_scores", 16'(ledr[7:0]), 16'h19);
        deal(5);
        tick();
        check("done_hex2", 16'(hex2), 16'(BLANK));
        check("done_ledr", 16'(ledr), 16'h119);

        // Dealer natural 8 vs player 0
        do_reset();
        deal(1); deal(8); deal(9); deal(10);
        tick(); tick();
        check("dnat_ledr", 16'(ledr), 16'h280);
        check("dnat_hex3", 16'(hex3), 16'(seg(8)));
        check("dnat_hex2", 16'(hex2), 16'(BLANK));
        check("dnat_hex5", 16'(hex5), 16'(BLANK));

        // Six aces: both draw third cards, tie 3/3
        do_reset();
        deal(1); deal(1); deal(1); deal(1);
        check("ace_hex2_pre", 16'(hex2), 16'(BLANK));
        check("ace_scores2", 16'(ledr[7:0]), 16'h22);
        deal(1);
        check("ace_hex2", 16'(hex2), 16'(seg(1)));
        check("ace_pscore3", 16'(ledr[3:0]), 16'd3);
        deal(1);
        check("ace_win_k0", 16'(ledr[9:8]), 16'd0);
        tick();
        check("ace_ledr", 16'(ledr), 16'h333);
        check("ace_hex5", 16'(hex5), 16'(seg(1)));

        // Player 7 stands, dealer 6 stands
        do_reset();
        deal(3); deal(2); deal(4); deal(4);
        tick(); tick();
        check("stand_ledr", 16'(ledr), 16'h167);
        check("stand_hex2", 16'(hex2), 16'(BLANK));
        check("stand_hex5", 16'(hex5), 16'(BLANK));
        deal(1);
        check("stand_ignore", 16'(hex2), 16'(BLANK));

        // Player draws 8, dealer on 3 stands: tie 3/3
        do_reset();
        deal(2); deal(1); deal(3); deal(2);
        deal(8);
        tick(); tick();
        check("d3p8_ledr", 16'(ledr), 16'h333);
        check("d3p8_hex2", 16'(hex2), 16'(seg(8)));
        check("d3p8_hex5", 16'(hex5), 16'(BLANK));
        deal(1);
        check("d3p8_ignore", 16'(hex5), 16'(BLANK));

        // Player draws 6, dealer on 6 draws a King and wins 6 vs 0
        do_reset();
        deal(2); deal(3); deal(2); deal(3);
        deal(6);
        deal(13);
        tick();
        check("d6p6_ledr", 16'(ledr), 16'h260);
        check("d6p6_hex5", 16'(hex5), 16'(seg(13)));
        check("d6p6_hex0", 16'(hex0), 16'(seg(2)));

        // Reset in the middle of a deal
        do_reset();
        deal(5); deal(7);
        check("mid_hex3", 16'(hex3), 16'(seg(7)));
        do_reset();
        check_cleared("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/task_5.md
# task_5

Top-level baccarat game block for the DE1-SoC lab build. A free-running card counter deals cards 1..13. A 9-state dealing/evaluation FSM advances one step per KEY[0] press. The block shows up to three player and three dealer cards on HEX0–HEX5, running scores on LEDR[7:0], and the winner on LEDR[9:8].

## Interface
- No parameters.
- CLOCK_50  in  1  sole clock; all registers update on its rising edge.
- KEY  in  4
  - KEY[3]: reset; synchronous, active-high.
  - KEY[0]: step input; one step per 0→1 transition sampled on CLOCK_50.
  - KEY[2:1]: unused.
- LEDR  out  10
  - [3:0] player score.
  - [7:4] dealer score.
  - [8] player-win light.
  - [9] dealer-win light.
- HEX0/HEX1/HEX2  out  7 each  player cards 1/2/3.
- HEX3/HEX4/HEX5  out  7 each  dealer cards 1/2/3.
- All HEX outputs are active-low segments.

## Operation
- **Card counter:** 4-bit; 1 (Ace) through 13 (King).
  - Increments every clock; 13 wraps to 1.
  - Card value: 1–9 face value; 10, J, Q, K all count 0.
- **Step detect:** prev register holds last KEY[0].
  - step = KEY[0] & ~prev.
  - prev resets to 1, so no spurious step after reset.
- **Card registers:** six 4-bit registers; 0 means empty.
  - A card load captures the counter value present at that clock edge, before that edge's increment.
- **Scores:** each is (sum of its three card values) mod 10, combinational from the card registers; empty cards count 0.
- **FSM states:** PC1, DC1, PC2, DC2, EVAL2, PC3, EVAL3, DC3, DONE.
  - PC1 –step→ DC1, loading pcard1.
  - DC1 –step→ PC2, loading dcard1.
  - PC2 –step→ DC2, loading pcard2.
  - DC2 –step→ EVAL2, loading dcard2.
  - EVAL2 (1 cycle, no step needed):
    - pscore≥8 or dscore≥8 (natural) → DONE.
    - else pscore≤5 → PC3.
    - else (player stands on 6/7): dscore≤5 → DC3, otherwise → DONE.
  - PC3 –step→ EVAL3, loading pcard3.
  - EVAL3 (1 cycle): dealer draws → DC3, else → DONE. Let p3 = value of pcard3; dealer draws when:
    - dscore 0–2: always.
    - dscore 3: p3≠8.
    - dscore 4: p3 in 2..7.
    - dscore 5: p3 in 4..7.
    - dscore 6: p3 in 6..7.
    - dscore 7: never.
  - DC3 –step→ DONE, loading dcard3.
  - DONE holds until reset; steps are ignored.
- **Win lights:** 0 in every state except DONE. In DONE:
  - pscore>dscore → LEDR[8]=1.
  - dscore>pscore → LEDR[9]=1.
  - tie → both lit.
- **HEX encoding** (gfedcba, active-low):
  - empty 1111111
  - A 0001000
  - 2 0100100
  - 3 0110000
  - 4 0011001
  - 5 0010010
  - 6 0000010
  - 7 1111000
  - 8 0000000
  - 9 0010000
  - 10 1000000
  - J 1100001
  - Q 0011000
  - K 0001001
  - Codes 14/15: blank.

## Timing
- **Reset** (KEY[3]=1 at a clock edge):
  - state=PC1, counter=1, all cards empty, prev=1.
  - Following the edge: all HEX = 1111111, LEDR = 0.
  - Reset overrides step and any in-progress state.
- **Card load:** the HEX digit and score update in the cycle after the step edge.
- **Win lights:**
  - Via EVAL2 or EVAL3 → DONE: valid 2 clocks after the loading step.
  - Via DC3 → DONE: valid 1 clock after the loading step.
- **Steps:** only one step is possible per KEY[0] rising edge. A step arriving while in EVAL2/EVAL3 is ignored.
- **Deal sequencing:** N clocks after reset, the counter reads ((N mod 13) + 1). This determines which card a step deals.

## Test plan
- **Reset:** assert KEY[3] for 1 clock → HEX0–HEX5 all 1111111, LEDR=0.
- **Player first card:** reset, step at the first clock → HEX0=Ace, LEDR[3:0]=1, LEDR[9:8]=0.
- **Two-card deal:**
  - Deals, in order: pcard1=A, dcard1=A, pcard2=8, dcard2=J.
  - Expected: HEX1=8, pscore 9, dscore 1, DONE with LEDR[8]=1, LEDR[9]=0.
- **Dealer natural:**
  - Deals, in order: pcard1=A, dcard1=8, pcard2=9, dcard2=10.
  - Expected: pscore 0, dscore 8, LEDR[9]=1, LEDR[8]=0.
- **Third cards:**
  - Six aces; player 2 → PC3, dealer 2 after p3=A → DC3.
  - Expected: HEX2=HEX5=A, scores 3/3, both lights lit (tie).
- **Stand rules:**
  - Case 1, expected: player 7 and dealer 6 → DONE directly; HEX2/HEX5 blank, LEDR[8]=1.
  - Case 2, expected: player draws p3=8 with dealer 3 → dealer stands.
  - Mid-game reset: everything clears.
